// File: rtl/display_multiplexado_7seg.sv
// display_multiplexado_7seg
//
// Drives a 3-position multiplexed 7-segment display (sign, tens, units)
// from the sign/tens/units outputs of a two-digit binary-to-BCD converter.
// A prescaler produces one tick every DIV clocks, and the scan advances one
// digit slot per tick. A load strobe latches a new value. A leading zero in
// the tens position is blanked, and a minus sign is shown for negative
// values. After a load, atualizado pulses once every digit has been
// refreshed with the new value.
//
// Parameters:
//   DIV          clock cycles per digit slot (>= 2)
//   ATIVO_BAIXO  1: segmentos/anodos inverted at the pins (active-low display)
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous reset, active low
//   carregar    load strobe; latches sinal/dezena/unidade
//   sinal       sign, 1 = negative
//   dezena      tens digit (BCD)
//   unidade     units digit (BCD)
//   habilitar   display enable; 0 blanks the outputs
//   segmentos   segments, bit0 = a ... bit6 = g
//   anodos      digit select: bit0 units, bit1 tens, bit2 sign
//   atualizado  one-cycle pulse: new value fully displayed
module display_multiplexado_7seg #(
    parameter int DIV         = 50000,
    parameter bit ATIVO_BAIXO = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carregar,
    input  logic       sinal,
    input  logic [3:0] dezena,
    input  logic [3:0] unidade,
    input  logic       habilitar,
    output logic [6:0] segmentos,
    output logic [2:0] anodos,
    output logic       atualizado
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    // Segment patterns (active high, bit0 = a)
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        S_UNI = 2'd0,
        S_DEZ = 2'd1,
        S_SIN = 2'd2
    } state_t;

    logic [PW-1:0] presc_q, presc_d;
    state_t        state_q, state_d;
    logic          sinal_q, sinal_d;
    logic [3:0]    dezena_q, dezena_d;
    logic [3:0]    unidade_q, unidade_d;
    logic [2:0]    cnt_q, cnt_d;
    logic          pendente_q, pendente_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          atualizado_q, atualizado_d;
    logic          tick;

    // BCD digit to segment pattern; codes 10-15 show 'E'
    function automatic logic [6:0] seg_code(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    // Prescaler and scan state machine. Neither is gated by habilitar.
    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        state_d = state_q;
        if (tick) begin
            case (state_q)
                S_UNI:   state_d = S_DEZ;
                S_DEZ:   state_d = S_SIN;
                S_SIN:   state_d = S_UNI;
                default: state_d = S_UNI;
            endcase
        end
    end

    // Value latch, loaded only on the strobe
    always_comb begin
        sinal_d   = sinal_q;
        dezena_d  = dezena_q;
        unidade_d = unidade_q;
        if (carregar) begin
            sinal_d   = sinal;
            dezena_d  = dezena;
            unidade_d = unidade;
        end
    end

    // Refresh handshake. A load always restarts the count, even when it
    // coincides with a tick, so that tick is not counted. Four counted
    // ticks cover one full scan of all three slots with the new value.
    always_comb begin
        cnt_d        = cnt_q;
        pendente_d   = pendente_q;
        atualizado_d = 1'b0;
        if (carregar) begin
            cnt_d      = 3'd0;
            pendente_d = 1'b1;
        end else if (tick && pendente_q) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
                pendente_d   = 1'b0;
                atualizado_d = 1'b1;
            end
        end
    end

    // Slot decode from the current state and latched value; registered,
    // so changes reach the pins one clock later.
    always_comb begin
        seg_d = SEG_BLANK;
        an_d  = 3'b000;
        if (habilitar) begin
            case (state_q)
                S_UNI: begin
                    seg_d = seg_code(unidade_q);
                    an_d  = 3'b001;
                end
                S_DEZ: begin
                    if (dezena_q != 4'd0) begin
                        seg_d = seg_code(dezena_q);
                        an_d  = 3'b010;
                    end
                end
                S_SIN: begin
                    if (sinal_q) begin
                        seg_d = SEG_MINUS;
                        an_d  = 3'b100;
                    end
                end
                default: begin
                    seg_d = SEG_BLANK;
                    an_d  = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            state_q      <= S_UNI;
            sinal_q      <= 1'b0;
            dezena_q     <= 4'd0;
            unidade_q    <= 4'd0;
            cnt_q        <= 3'd0;
            pendente_q   <= 1'b0;
            seg_q        <= SEG_BLANK;
            an_q         <= 3'b000;
            atualizado_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            state_q      <= state_d;
            sinal_q      <= sinal_d;
            dezena_q     <= dezena_d;
            unidade_q    <= unidade_d;
            cnt_q        <= cnt_d;
            pendente_q   <= pendente_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            atualizado_q <= atualizado_d;
        end
    end

    // Polarity is applied after the register, so reset still yields the
    // inactive level at the pins.
    assign segmentos  = ATIVO_BAIXO ? ~seg_q : seg_q;
    assign anodos     = ATIVO_BAIXO ? ~an_q : an_q;
    assign atualizado = atualizado_q;

endmodule

// File: tb/tb_display_multiplexado_7seg.sv
// tb_display_multiplexado_7seg
//
// Two instances share all inputs: one active-high (ATIVO_BAIXO=0) and one
// active-low (ATIVO_BAIXO=1), both with DIV=4. A cycle model derives the
// scan slot and tick positions from the number of clock edges since reset.
module tb_display_multiplexado_7seg;

    localparam int DIV = 4;

    logic       clock;
    logic       reset;
    logic       carregar;
    logic       sinal;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       habilitar;

    logic [6:0] seg_a, seg_b;
    logic [2:0] an_a, an_b;
    logic       upd_a, upd_b;

    int n_tests;
    int n_fail;

    logic [21:0] obs;
    logic [21:0] expv;

    // Model state
    logic [6:0] tab [16];
    int         m_n;
    logic       m_sig;
    logic [3:0] m_ten;
    logic [3:0] m_uni;
    logic       m_pend;
    int         m_ticks;
    logic [6:0] m_seg;
    logic [2:0] m_an;
    logic       m_upd;

    display_multiplexado_7seg #(.DIV(DIV), .ATIVO_BAIXO(1'b0)) dut_a (
        .clock(clock), .reset(reset), .carregar(carregar), .sinal(sinal),
        .dezena(dezena), .unidade(unidade), .habilitar(habilitar),
        .segmentos(seg_a), .anodos(an_a), .atualizado(upd_a)
    );

    display_multiplexado_7seg #(.DIV(DIV), .ATIVO_BAIXO(1'b1)) dut_b (
        .clock(clock), .reset(reset), .carregar(carregar), .sinal(sinal),
        .dezena(dezena), .unidade(unidade), .habilitar(habilitar),
        .segmentos(seg_b), .anodos(an_b), .atualizado(upd_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the slot shown after edge n is the one active during
    // edge n, i.e. (n / DIV) mod 3; a tick happens on every DIV-th edge.
    always @(posedge clock or negedge reset) begin
        int slot;
        bit is_tick;
        if (!reset) begin
            m_n     = 0;
            m_sig   = 1'b0;
            m_ten   = 4'd0;
            m_uni   = 4'd0;
            m_pend  = 1'b0;
            m_ticks = 0;
            m_seg   = 7'h00;
            m_an    = 3'b000;
            m_upd   = 1'b0;
        end else begin
            slot    = (m_n / DIV) % 3;
            is_tick = ((m_n % DIV) == DIV - 1);
            m_seg   = 7'h00;
            m_an    = 3'b000;
            if (habilitar) begin
                if (slot == 0) begin
                    m_seg = tab[m_uni];
                    m_an  = 3'b001;
                end else if (slot == 1 && m_ten != 4'd0) begin
                    m_seg = tab[m_ten];
                    m_an  = 3'b010;
                end else if (slot == 2 && m_sig) begin
                    m_seg = 7'h40;
                    m_an  = 3'b100;
                end
            end
            m_upd = 1'b0;
            if (carregar) begin
                m_pend  = 1'b1;
                m_ticks = 0;
                m_sig   = sinal;
                m_ten   = dezena;
                m_uni   = unidade;
            end else if (is_tick && m_pend) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == 4) begin
                    m_upd  = 1'b1;
                    m_pend = 1'b0;
                end
            end
            m_n = m_n + 1;
        end
    end

    task automatic test_reset();
        reset     = 1'b0;
        carregar  = 1'b0;
        sinal     = 1'b0;
        dezena    = 4'd0;
        unidade   = 4'd0;
        habilitar = 1'b1;
        repeat (3) begin
            @(negedge clock);
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {7'h00, 3'b000, 1'b0, 7'h7F, 3'b111, 1'b0};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL reset_state: got %h expected %h", obs, expv);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_idle_scan();
        int pulses = 0;
        for (int i = 0; i < 3 * 3 * DIV; i++) begin
            @(negedge clock);
            if (upd_a) pulses++;
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {m_seg, m_an, m_upd, ~m_seg, ~m_an, m_upd};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL idle_scan cyc=%0d: got %h expected %h", i, obs, expv);
            end
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("[TB] FAIL idle_no_pulse: got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_load(input logic s, input logic [3:0] d, input logic [3:0] u);
        int pulses = 0;
        @(negedge clock);
        carregar = 1'b1;
        sinal    = s;
        dezena   = d;
        unidade  = u;
        @(negedge clock);
        carregar = 1'b0;
        sinal    = $urandom_range(0, 1);
        dezena   = 4'($urandom_range(0, 15));
        unidade  = 4'($urandom_range(0, 15));
        for (int i = 0; i < 5 * DIV; i++) begin
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {m_seg, m_an, m_upd, ~m_seg, ~m_an, m_upd};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL load_%0h%0h%0h cyc=%0d: got %h expected %h",
                         s, d, u, i, obs, expv);
            end
            if (upd_a) pulses++;
            @(negedge clock);
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("[TB] FAIL load_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int guard  = 0;
        // Align so the load is sampled on a tick edge
        @(negedge clock);
        while ((m_n % DIV) != DIV - 1 && guard < 2 * DIV) begin
            @(negedge clock);
            guard++;
        end
        n_tests++;
        if (guard >= 2 * DIV) begin
            n_fail++;
            $display("[TB] FAIL b2b_align: got guard %0d expected < %0d", guard, 2 * DIV);
        end
        carregar = 1'b1;
        sinal    = 1'b1;
        dezena   = 4'd9;
        unidade  = 4'd1;
        @(negedge clock);
        carregar = 1'b0;
        for (int i = 0; i < 2 * DIV - 1; i++) begin
            if (upd_a) pulses++;
            @(negedge clock);
        end
        if (upd_a) pulses++;
        carregar = 1'b1;
        sinal    = 1'b0;
        dezena   = 4'd3;
        unidade  = 4'd8;
        @(negedge clock);
        carregar = 1'b0;
        for (int i = 0; i < 6 * DIV; i++) begin
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {m_seg, m_an, m_upd, ~m_seg, ~m_an, m_upd};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL back_to_back cyc=%0d: got %h expected %h", i, obs, expv);
            end
            if (upd_a) pulses++;
            @(negedge clock);
        end
        n_tests++;
        if (pulses !== 1) begin
            n_fail++;
            $display("[TB] FAIL b2b_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_enable();
        @(negedge clock);
        carregar = 1'b1;
        sinal    = 1'b1;
        dezena   = 4'd6;
        unidade  = 4'd4;
        @(negedge clock);
        carregar  = 1'b0;
        habilitar = 1'b0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clock);
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {m_seg, m_an, m_upd, ~m_seg, ~m_an, m_upd};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL enable_off cyc=%0d: got %h expected %h", i, obs, expv);
            end
        end
        habilitar = 1'b1;
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clock);
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {m_seg, m_an, m_upd, ~m_seg, ~m_an, m_upd};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL enable_on cyc=%0d: got %h expected %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        carregar = 1'b1;
        sinal    = 1'b1;
        dezena   = 4'd8;
        unidade  = 4'd8;
        @(negedge clock);
        carregar = 1'b0;
        repeat (DIV + 1) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
        expv = {7'h00, 3'b000, 1'b0, 7'h7F, 3'b111, 1'b0};
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL reset_async: got %h expected %h", obs, expv);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({seg_a, an_a} !== {7'h3F, 3'b001}) begin
            n_fail++;
            $display("[TB] FAIL reset_latch_cleared: got %h/%b expected 3f/001", seg_a, an_a);
        end
        for (int i = 0; i < 3 * DIV; i++) begin
            @(negedge clock);
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {m_seg, m_an, m_upd, ~m_seg, ~m_an, m_upd};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL after_reset cyc=%0d: got %h expected %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            obs  = {seg_a, an_a, upd_a, seg_b, an_b, upd_b};
            expv = {m_seg, m_an, m_upd, ~m_seg, ~m_an, m_upd};
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("[TB] FAIL random cyc=%0d: got %h expected %h", i, obs, expv);
            end
            carregar  = ($urandom_range(0, 19) == 0);
            sinal     = $urandom_range(0, 1);
            dezena    = 4'($urandom_range(0, 15));
            unidade   = 4'($urandom_range(0, 15));
            habilitar = ($urandom_range(0, 9) != 0);
        end
        carregar  = 1'b0;
        habilitar = 1'b1;
    endtask

    initial begin
        tab[0]  = 7'h3F; tab[1]  = 7'h06; tab[2]  = 7'h5B; tab[3]  = 7'h4F;
        tab[4]  = 7'h66; tab[5]  = 7'h6D; tab[6]  = 7'h7D; tab[7]  = 7'h07;
        tab[8]  = 7'h7F; tab[9]  = 7'h6F;
        for (int k = 10; k < 16; k++) tab[k] = 7'h79;
        n_tests = 0;
        n_fail  = 0;

        test_reset();
        test_idle_scan();
        test_load(1'b1, 4'd2, 4'd7);
        test_load(1'b0, 4'd0, 4'd5);
        test_load(1'b0, 4'hC, 4'd3);
        test_back_to_back();
        test_enable();
        test_reset_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
